// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage.
//   - Flag bit positions inside the 4-bit {N,Z,C,V} flag vector.
//   - Skid buffer state encoding.
//   - Payload width of a registered beat (result plus flags) at the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_W     = 8;
    localparam int unsigned PAYLOAD_W = ALU_W + 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry skid buffer with a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready comes straight from a flop
//   in_data             payload captured on input fire
//   out_valid/out_ready downstream handshake; out_valid comes straight from a flop
//   out_data            head-of-queue payload, always the main register
module skid_buf
    import alu_pkg::*;
#(
    parameter int unsigned PW = PAYLOAD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    skid_state_e   state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_ready_q, out_valid_q;
    logic          in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage for the 8-bit adders: derives {N,Z,C,V} from the raw adder outputs,
// buffers result plus flags in a 2-entry skid buffer, and counts signed-overflow beats.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   sum, cout             raw adder outputs
//   a_msb, b_msb          operand MSBs as seen by the adder (b after SUB inversion)
//   out_valid/out_ready   downstream handshake
//   out_result, out_flags registered sum and {N,Z,C,V}
//   ovf_count             saturating count of accepted beats with V=1
//   clr_cnt               synchronous clear of ovf_count
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  sum,
    input  logic          cout,
    input  logic          a_msb,
    input  logic          b_msb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [3:0]    out_flags,
    output logic [CW-1:0] ovf_count,
    input  logic          clr_cnt
);

    localparam int unsigned PW      = W + 4;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [3:0]    flags;
    logic [PW-1:0] payload_out;
    logic          ovf_fire;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = sum[W-1];
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_C] = cout;
        // Same-sign operands producing a result of the other sign.
        flags[FLAG_V] = (a_msb == b_msb) && (sum[W-1] != a_msb);
    end

    skid_buf #(
        .PW (PW)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({sum, flags}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (payload_out)
    );

    assign out_result = payload_out[PW-1:4];
    assign out_flags  = payload_out[3:0];

    assign ovf_fire = in_valid & in_ready & flags[FLAG_V];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            // A clear coinciding with an overflow beat still counts that beat.
            cnt_d = ovf_fire ? CNT_ONE : '0;
        end else if (ovf_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_count = cnt_q;

endmodule
